// File: rtl/core_sequencer_if.sv
// Start/halt handshake, ROM fetch and datapath strobe bundle between the
// sequencer (master) and the rest of the core (slave).
interface core_sequencer_if #(
    parameter int INSTR_W = 9,
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [INSTR_W-1:0] instr;
    logic               branch_cond;
    logic               mem_ready;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               alu_en;
    logic               reg_we;
    logic               mem_re;
    logic               mem_we;
    logic               halt;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        input  start, instr, branch_cond, mem_ready,
        output pc, ir, alu_en, reg_we, mem_re, mem_we, halt,
               cycle_count, instr_count
    );

    modport slave (
        output start, instr, branch_cond, mem_ready,
        input  pc, ir, alu_en, reg_we, mem_re, mem_we, halt,
               cycle_count, instr_count
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: owns pc, ir and the phase FSM, and issues
// one-cycle strobes to the register file, ALU and data memory.
module core_sequencer #(
    parameter int          INSTR_W  = 9,
    parameter int          PC_W     = 8,
    parameter int unsigned START_PC = 0,
    parameter int          CNT_W    = 16
) (
    input logic              clk,
    input logic              reset,
    core_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_e;

    typedef enum logic [2:0] {
        OP_ALU_REG = 3'd0, OP_ALU_IMM = 3'd1, OP_LOAD = 3'd2, OP_STORE = 3'd3,
        OP_BRANCH  = 3'd4, OP_JUMP    = 3'd5, OP_NOP  = 3'd6, OP_HALT  = 3'd7
    } opcode_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               halt_q, halt_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;

    logic               alu_en, reg_we, mem_re, mem_we, retire;
    opcode_e            opcode;
    logic [PC_W-1:0]    pc_inc, pc_rel;

    assign opcode = opcode_e'(ir_q[INSTR_W-1 -: 3]);
    assign pc_inc = pc_q + PC_W'(1);
    // Offset is a 6-bit two's-complement field; the add wraps modulo 2^PC_W.
    assign pc_rel = pc_q + {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};

    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        halt_d      = halt_q;
        cycle_d     = cycle_q;
        instr_cnt_d = instr_cnt_q;
        alu_en      = 1'b0;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        retire      = 1'b0;

        if (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} && cycle_q != '1)
            cycle_d = cycle_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_FETCH;
                    pc_d        = PC_W'(START_PC);
                    cycle_d     = '0;
                    instr_cnt_d = '0;
                    halt_d      = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = bus.instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALTED;
                    halt_d  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (opcode)
                    OP_ALU_REG, OP_ALU_IMM: state_d = S_WB;
                    OP_LOAD, OP_STORE:      state_d = S_MEM;
                    OP_BRANCH: begin
                        pc_d   = bus.branch_cond ? pc_rel : pc_inc;
                        retire = 1'b1;
                    end
                    OP_JUMP: begin
                        pc_d   = pc_rel;
                        retire = 1'b1;
                    end
                    default: begin
                        pc_d   = pc_inc;
                        retire = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                mem_re = (opcode == OP_LOAD);
                mem_we = (opcode != OP_LOAD);
                if (bus.mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_d   = pc_inc;
                        retire = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_d   = pc_inc;
                retire = 1'b1;
            end
            S_HALTED: begin
                if (!bus.start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
            state_d     = S_FETCH;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_W'(START_PC);
            ir_q        <= '0;
            halt_q      <= 1'b0;
            cycle_q     <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            halt_q      <= halt_d;
            cycle_q     <= cycle_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Strobes decode straight from state, so an async reset drops them at once.
    assign bus.pc          = pc_q;
    assign bus.ir          = ir_q;
    assign bus.alu_en      = alu_en;
    assign bus.reg_we      = reg_we;
    assign bus.mem_re      = mem_re;
    assign bus.mem_we      = mem_we;
    assign bus.halt        = halt_q;
    assign bus.cycle_count = cycle_q;
    assign bus.instr_count = instr_cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed programs plus random ROMs,
// checked cycle by cycle against an instruction-level reference model.
module tb_core_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_sequencer_if bus ();
    core_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    logic [8:0] rom [256];
    assign bus.instr = rom[bus.pc];

    localparam logic [8:0] I_HALT = 9'h1C0;
    localparam logic [8:0] I_NOP  = 9'h180;

    // Strobe pattern {alu_en, reg_we, mem_re, mem_we}.
    localparam logic [3:0] ST_NONE = 4'b0000;
    localparam logic [3:0] ST_ALU  = 4'b1000;
    localparam logic [3:0] ST_WB   = 4'b0100;
    localparam logic [3:0] ST_RD   = 4'b0010;
    localparam logic [3:0] ST_WR   = 4'b0001;

    typedef struct {
        logic [3:0]  strb;
        logic [7:0]  pc;
        logic [8:0]  ir;
        bit          ir_v;
        logic [15:0] cc;
        logic [15:0] ic;
        bit          bc;
        bit          mr;
    } cyc_t;

    cyc_t        exp_q[$];
    bit          bc_q[$];
    int          mem_delay_cfg;
    logic [7:0]  exp_pc;
    logic [15:0] exp_cc, exp_ic;

    int compared   = 0;
    int mismatched = 0;

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic [3:0] strb, int pcv, logic [8:0] ir, bit ir_v,
                                 int ic, bit bc, bit mr);
        cyc_t c;
        c.strb = strb;
        c.pc   = pcv[7:0];
        c.ir   = ir;
        c.ir_v = ir_v;
        c.cc   = 16'(exp_q.size());
        c.ic   = 16'(ic);
        c.bc   = bc;
        c.mr   = mr;
        exp_q.push_back(c);
    endfunction

    // Instruction-level model: walks the program and lists what each cycle
    // should look like, along with the stimulus to apply in that cycle.
    function automatic bit build_model();
        int pcv = 0;
        int ic  = 0;
        exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            logic [8:0]        w  = rom[pcv];
            int                op = int'(w[8:6]);
            logic signed [5:0] so = w[5:0];
            push(ST_NONE, pcv, w, 1'b0, ic, rb(), rb());
            push(ST_NONE, pcv, w, 1'b1, ic, rb(), rb());
            if (op == 7) begin
                exp_pc = pcv[7:0];
                exp_ic = 16'(ic);
                exp_cc = 16'(exp_q.size());
                return 1'b1;
            end
            case (op)
                0, 1: begin
                    push(ST_ALU, pcv, w, 1'b1, ic, rb(), rb());
                    push(ST_WB, pcv, w, 1'b1, ic, rb(), rb());
                    pcv = pcv + 1;
                end
                2, 3: begin
                    int d = (mem_delay_cfg < 0) ? int'($urandom_range(0, 3)) : mem_delay_cfg;
                    logic [3:0] ms = (op == 2) ? ST_RD : ST_WR;
                    push(ST_ALU, pcv, w, 1'b1, ic, rb(), rb());
                    for (int k = 0; k < d; k++) push(ms, pcv, w, 1'b1, ic, rb(), 1'b0);
                    push(ms, pcv, w, 1'b1, ic, rb(), 1'b1);
                    if (op == 2) push(ST_WB, pcv, w, 1'b1, ic, rb(), rb());
                    pcv = pcv + 1;
                end
                4: begin
                    bit bc = (bc_q.size() > 0) ? bc_q.pop_front() : rb();
                    push(ST_ALU, pcv, w, 1'b1, ic, bc, rb());
                    pcv = bc ? pcv + int'(so) : pcv + 1;
                end
                5: begin
                    push(ST_ALU, pcv, w, 1'b1, ic, rb(), rb());
                    pcv = pcv + int'(so);
                end
                default: begin
                    push(ST_ALU, pcv, w, 1'b1, ic, rb(), rb());
                    pcv = pcv + 1;
                end
            endcase
            pcv = pcv & 255;
            ic  = ic + 1;
        end
        return 1'b0;
    endfunction

    function automatic logic [3:0] strobes();
        return {bus.alu_en, bus.reg_we, bus.mem_re, bus.mem_we};
    endfunction

    task automatic do_reset();
        bus.start       = 1'b0;
        bus.branch_cond = 1'b0;
        bus.mem_ready   = 1'b0;
        reset           = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts the model's program from IDLE and follows it to HALTED.
    task automatic run_program(input string name, input bit hold_start);
        bit bad = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        foreach (exp_q[i]) begin
            cyc_t e = exp_q[i];
            @(negedge clk);
            if (!bad) begin
                compared++;
                if (strobes() !== e.strb || bus.halt !== 1'b0 || bus.pc !== e.pc ||
                    bus.cycle_count !== e.cc || bus.instr_count !== e.ic ||
                    (e.ir_v && bus.ir !== e.ir)) begin
                    $display("FAIL %s cycle %0d: got strobes=%b halt=%b pc=%h ir=%h cc=%0d ic=%0d, want strobes=%b halt=0 pc=%h ir=%h cc=%0d ic=%0d",
                             name, i, strobes(), bus.halt, bus.pc, bus.ir, bus.cycle_count,
                             bus.instr_count, e.strb, e.pc, e.ir, e.cc, e.ic);
                    mismatched++;
                    bad = 1'b1;
                end
            end
            bus.branch_cond = e.bc;
            bus.mem_ready   = e.mr;
            bus.start       = hold_start ? 1'b1 : rb();
        end
        @(negedge clk);
        compared++;
        if (bus.halt !== 1'b1 || strobes() !== ST_NONE || bus.pc !== exp_pc ||
            bus.cycle_count !== exp_cc || bus.instr_count !== exp_ic) begin
            $display("FAIL %s halted: got halt=%b strobes=%b pc=%h cc=%0d ic=%0d, want halt=1 strobes=0000 pc=%h cc=%0d ic=%0d",
                     name, bus.halt, strobes(), bus.pc, bus.cycle_count, bus.instr_count,
                     exp_pc, exp_cc, exp_ic);
            mismatched++;
        end
    endtask

    task automatic expect_final(input string name, input logic [7:0] pc_w,
                                input logic [15:0] cc_w, input logic [15:0] ic_w);
        compared++;
        if (bus.pc !== pc_w || bus.cycle_count !== cc_w || bus.instr_count !== ic_w) begin
            $display("FAIL %s: got pc=%h cc=%0d ic=%0d, want pc=%h cc=%0d ic=%0d",
                     name, bus.pc, bus.cycle_count, bus.instr_count, pc_w, cc_w, ic_w);
            mismatched++;
        end
    endtask

    task automatic load_program(input logic [8:0] prog [$]);
        foreach (rom[a]) rom[a] = I_HALT;
        foreach (prog[a]) rom[a] = prog[a];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        compared++;
        if (bus.pc !== 8'h00 || bus.ir !== 9'h000 || strobes() !== ST_NONE || bus.halt !== 1'b0 ||
            bus.cycle_count !== 16'd0 || bus.instr_count !== 16'd0) begin
            $display("FAIL reset: got pc=%h ir=%h strobes=%b halt=%b cc=%0d ic=%0d, want all zero",
                     bus.pc, bus.ir, strobes(), bus.halt, bus.cycle_count, bus.instr_count);
            mismatched++;
        end
        do_reset();
    endtask

    task automatic test_alu_halt_handshake();
        load_program('{9'h000, I_HALT});
        bc_q.delete();
        mem_delay_cfg = -1;
        void'(build_model());
        run_program("alu_halt", 1'b1);
        expect_final("alu_halt_totals", 8'h01, 16'd6, 16'd1);
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (bus.halt !== 1'b1 || strobes() !== ST_NONE || bus.pc !== 8'h01 ||
                bus.cycle_count !== 16'd6 || bus.instr_count !== 16'd1) begin
                $display("FAIL halted_hold: got halt=%b pc=%h cc=%0d ic=%0d, want halt=1 pc=01 cc=6 ic=1",
                         bus.halt, bus.pc, bus.cycle_count, bus.instr_count);
                mismatched++;
            end
        end
        bus.start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            compared++;
            if (bus.halt !== 1'b1 || strobes() !== ST_NONE || bus.pc !== 8'h01) begin
                $display("FAIL idle_after_halt: got halt=%b strobes=%b pc=%h, want halt=1 strobes=0000 pc=01",
                         bus.halt, strobes(), bus.pc);
                mismatched++;
            end
        end
        void'(build_model());
        run_program("restart", 1'b1);
        expect_final("restart_totals", 8'h01, 16'd6, 16'd1);
    endtask

    task automatic test_load_wait();
        do_reset();
        load_program('{9'h080, I_HALT});
        mem_delay_cfg = 3;
        void'(build_model());
        run_program("load_wait", 1'b0);
        expect_final("load_wait_totals", 8'h01, 16'd10, 16'd1);
        mem_delay_cfg = -1;
    endtask

    task automatic test_branch(input bit taken);
        do_reset();
        load_program('{I_NOP, I_NOP, 9'h13C});
        bc_q = '{taken};
        void'(build_model());
        run_program(taken ? "branch_taken" : "branch_not_taken", 1'b0);
        expect_final(taken ? "branch_taken_pc" : "branch_not_taken_pc",
                     taken ? 8'hFE : 8'h03, 16'd11, 16'd3);
    endtask

    task automatic test_jump_wrap();
        do_reset();
        load_program('{9'h13F});
        rom[255] = 9'h141;
        bc_q = '{1'b1, 1'b0};
        void'(build_model());
        run_program("jump_wrap", 1'b0);
        expect_final("jump_wrap_pc", 8'h01, 16'd11, 16'd3);
    endtask

    task automatic test_reset_in_mem();
        do_reset();
        load_program('{9'h0C0, I_HALT});
        @(negedge clk);
        bus.start = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if (bus.mem_we !== 1'b1) begin
            $display("FAIL store_in_mem: got mem_we=%b, want 1", bus.mem_we);
            mismatched++;
        end
        reset = 1'b1;
        #1;
        compared++;
        if (strobes() !== ST_NONE || bus.pc !== 8'h00 || bus.halt !== 1'b0 ||
            bus.cycle_count !== 16'd0 || bus.instr_count !== 16'd0) begin
            $display("FAIL reset_in_mem: got strobes=%b pc=%h halt=%b cc=%0d ic=%0d, want all zero",
                     strobes(), bus.pc, bus.halt, bus.cycle_count, bus.instr_count);
            mismatched++;
        end
        do_reset();
        void'(build_model());
        run_program("store_rerun", 1'b0);
    endtask

    task automatic test_random_programs();
        for (int p = 0; p < 20; p++) begin
            bit ok = 1'b0;
            bc_q.delete();
            for (int t = 0; t < 200 && !ok; t++) begin
                foreach (rom[a]) rom[a] = 9'($urandom_range(0, 511));
                ok = build_model();
            end
            if (!ok) continue;
            if (rb()) begin
                do_reset();
            end else begin
                bus.start = 1'b0;
                @(negedge clk);
            end
            run_program($sformatf("random_%0d", p), 1'b0);
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.branch_cond = 1'b0;
        bus.mem_ready   = 1'b0;
        mem_delay_cfg   = -1;
        foreach (rom[a]) rom[a] = I_HALT;
        test_reset();
        test_alu_halt_handshake();
        test_load_wait();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jump_wrap();
        test_reset_in_mem();
        test_random_programs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
